frame_parser_stream: RTL and testbench



---
 rtl/frame_parser_pkg.sv | 36 +++
 rtl/crc32_byte.sv | 15 +
 rtl/frame_parser_stream.sv | 257 +++++++++++++++++++++++++
 tb/tb_frame_parser_stream.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_parser_pkg.sv
// Shared definitions for the framed byte-stream parser: FSM states, CRC-32
// constants and a byte-wise reflected CRC-32 update.
package frame_parser_pkg;

    localparam int unsigned LEN_W = 16;

    localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN_H,
        S_LEN_L,
        S_PAYLOAD,
        S_CRC,
        S_CHECK,
        S_DRAIN
    } state_e;

    // Reflected CRC: data enters LSB first
    function automatic logic [31:0] crc32_update(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte step of the reflected CRC-32; also used by the
// transmit framer.
module crc32_byte
    import frame_parser_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        crc_o = crc32_update(crc_i, data_i);
    end

endmodule

// File: rtl/frame_parser_stream.sv
// Framed byte-stream parser: validates SOF/version/length/CRC-32, buffers the
// payload and releases only CRC-good frames on a valid/ready/last stream.
module frame_parser_stream
    import frame_parser_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE       = 8'hAA,
    parameter int unsigned MAX_PAYLOAD    = 256,
    parameter logic [3:0]  VER_MASK       = 4'b0011,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [5:0]       frame_cmd,
    output logic [1:0]       frame_ver,
    output logic [LEN_W-1:0] frame_len,
    output logic             err_crc,
    output logic             err_len,
    output logic             err_ver,
    output logic             err_timeout,
    output logic             rx_overrun,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam int unsigned     AW      = $clog2(MAX_PAYLOAD);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);
    localparam logic [31:0]     TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [7:0] mem [MAX_PAYLOAD];

    state_e           state_q;
    logic [1:0]       ver_q;
    logic [5:0]       cmd_q;
    logic [7:0]       len_h_q;
    logic [LEN_W-1:0] len_q;
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [31:0]      crc_q;
    logic [31:0]      crc_rx_q;
    logic [1:0]       crc_cnt_q;
    logic [31:0]      idle_q;

    logic [7:0]       out_data_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [5:0]       frame_cmd_q;
    logic [1:0]       frame_ver_q;
    logic [LEN_W-1:0] frame_len_q;
    logic             err_crc_q;
    logic             err_len_q;
    logic             err_ver_q;
    logic             err_timeout_q;
    logic             rx_overrun_q;
    logic [CNT_W-1:0] good_cnt_q;
    logic [CNT_W-1:0] bad_cnt_q;

    logic [31:0]      crc_d;
    logic [LEN_W-1:0] len_d;
    logic [LEN_W-1:0] len_last;
    logic             wr_last;
    logic             rd_last_next;
    logic             in_frame;
    logic             to_fire;
    logic             mem_we;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (rx_data),
        .crc_o  (crc_d)
    );

    assign len_d        = {len_h_q, rx_data};
    assign len_last     = len_q - LEN_W'(1);
    assign wr_last      = (LEN_W'(wptr_q) == len_last);
    assign rd_last_next = ((LEN_W'(rptr_q) + LEN_W'(1)) == len_last);
    assign in_frame     = (state_q == S_HDR) || (state_q == S_LEN_H) || (state_q == S_LEN_L) ||
                          (state_q == S_PAYLOAD) || (state_q == S_CRC);
    assign to_fire      = (TIMEOUT_CYCLES != 0) && (idle_q == TO_LAST);
    assign mem_we       = (state_q == S_PAYLOAD) && rx_valid;

    // Payload RAM has no reset so it maps onto block memory
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ver_q         <= '0;
            cmd_q         <= '0;
            len_h_q       <= '0;
            len_q         <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            crc_q         <= '0;
            crc_rx_q      <= '0;
            crc_cnt_q     <= '0;
            idle_q        <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            frame_cmd_q   <= '0;
            frame_ver_q   <= '0;
            frame_len_q   <= '0;
            err_crc_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_ver_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
        end else begin
            err_crc_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_ver_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            rx_overrun_q  <= 1'b0;

            if (in_frame && !rx_valid && !to_fire) begin
                idle_q <= idle_q + 32'd1;
            end else begin
                idle_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (rx_valid && (rx_data == SOF_BYTE)) begin
                        state_q <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (rx_valid) begin
                        ver_q <= rx_data[7:6];
                        cmd_q <= rx_data[5:0];
                        if (!VER_MASK[rx_data[7:6]]) begin
                            err_ver_q <= 1'b1;
                            bad_cnt_q <= sat_inc(bad_cnt_q);
                            state_q   <= S_IDLE;
                        end else begin
                            state_q <= S_LEN_H;
                        end
                    end
                end
                S_LEN_H: begin
                    if (rx_valid) begin
                        len_h_q <= rx_data;
                        state_q <= S_LEN_L;
                    end
                end
                S_LEN_L: begin
                    if (rx_valid) begin
                        len_q <= len_d;
                        if ((len_d == '0) || (len_d > MAX_LEN)) begin
                            err_len_q <= 1'b1;
                            bad_cnt_q <= sat_inc(bad_cnt_q);
                            state_q   <= S_IDLE;
                        end else begin
                            wptr_q  <= '0;
                            crc_q   <= CRC32_INIT;
                            state_q <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_valid) begin
                        crc_q  <= crc_d;
                        wptr_q <= wptr_q + AW'(1);
                        if (wr_last) begin
                            crc_cnt_q <= '0;
                            state_q   <= S_CRC;
                        end
                    end
                end
                S_CRC: begin
                    if (rx_valid) begin
                        crc_rx_q  <= {rx_data, crc_rx_q[31:8]};
                        crc_cnt_q <= crc_cnt_q + 2'd1;
                        if (crc_cnt_q == 2'd3) begin
                            state_q <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    // First byte is read here so out_valid never shows stale data
                    if ((crc_q ^ CRC32_XOROUT) == crc_rx_q) begin
                        frame_cmd_q <= cmd_q;
                        frame_ver_q <= ver_q;
                        frame_len_q <= len_q;
                        good_cnt_q  <= sat_inc(good_cnt_q);
                        rptr_q      <= '0;
                        out_data_q  <= mem['0];
                        out_last_q  <= (len_q == LEN_W'(1));
                        out_valid_q <= 1'b1;
                        state_q     <= S_DRAIN;
                    end else begin
                        err_crc_q <= 1'b1;
                        bad_cnt_q <= sat_inc(bad_cnt_q);
                        state_q   <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            rptr_q     <= rptr_q + AW'(1);
                            out_data_q <= mem[rptr_q + AW'(1)];
                            out_last_q <= rd_last_next;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (((state_q == S_CHECK) || (state_q == S_DRAIN)) && rx_valid) begin
                rx_overrun_q <= 1'b1;
            end

            // The case above only acts on rx_valid, so a timeout never collides with it
            if (in_frame && !rx_valid && to_fire) begin
                err_timeout_q <= 1'b1;
                bad_cnt_q     <= sat_inc(bad_cnt_q);
                state_q       <= S_IDLE;
            end
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign frame_cmd   = frame_cmd_q;
    assign frame_ver   = frame_ver_q;
    assign frame_len   = frame_len_q;
    assign err_crc     = err_crc_q;
    assign err_len     = err_len_q;
    assign err_ver     = err_ver_q;
    assign err_timeout = err_timeout_q;
    assign rx_overrun  = rx_overrun_q;
    assign good_cnt    = good_cnt_q;
    assign bad_cnt     = bad_cnt_q;

endmodule

// File: tb/tb_frame_parser_stream.sv
// Directed and randomized bench for frame_parser_stream with a queue-based
// reference model of the frame format and reflected CRC-32.
module tb_frame_parser_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [5:0]  frame_cmd;
    logic [1:0]  frame_ver;
    logic [15:0] frame_len;
    logic        err_crc, err_len, err_ver, err_timeout, rx_overrun;
    logic [15:0] good_cnt, bad_cnt;

    int checks = 0;
    int errors = 0;

    frame_parser_stream #(
        .SOF_BYTE       (8'hAA),
        .MAX_PAYLOAD    (256),
        .VER_MASK       (4'b0011),
        .TIMEOUT_CYCLES (50),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .frame_cmd   (frame_cmd),
        .frame_ver   (frame_ver),
        .frame_len   (frame_len),
        .err_crc     (err_crc),
        .err_len     (err_len),
        .err_ver     (err_ver),
        .err_timeout (err_timeout),
        .rx_overrun  (rx_overrun),
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0]  got_q[$];
    logic        got_last_q[$];
    logic [5:0]  got_cmd;
    logic [1:0]  got_ver;
    logic [15:0] got_len;
    int          frames_out = 0;
    int          n_crc = 0, n_len = 0, n_ver = 0, n_to = 0, n_ovr = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;
    logic [23:0] prev_side;

    always @(negedge clk) begin
        int nerr;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
                check("stall_side", {frame_ver, frame_cmd, frame_len}, prev_side);
            end
            nerr = int'(err_crc) + int'(err_len) + int'(err_ver) + int'(err_timeout);
            if (nerr != 0) check("err_single", nerr, 1);
            n_crc += int'(err_crc);
            n_len += int'(err_len);
            n_ver += int'(err_ver);
            n_to  += int'(err_timeout);
            n_ovr += int'(rx_overrun);
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_last_q.push_back(out_last);
                if (out_last) begin
                    frames_out++;
                    got_cmd = frame_cmd;
                    got_ver = frame_ver;
                    got_len = frame_len;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            prev_side  = {frame_ver, frame_cmd, frame_len};
        end
    end

    // out_ready: 0 always-on, 1 random, 2 repeating 1-0-0-1, 3 held low
    int   rdy_mode = 0;
    int   pidx = 0;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin out_ready = pat[pidx % 4]; pidx++; end
            default: out_ready = 1'b0;
        endcase
    end

    // ---------------- reference model ----------------
    logic [7:0] pl[$];
    int exp_good = 0, exp_bad = 0, exp_frames = 0, rd_idx = 0;
    int e_crc = 0, e_len = 0, e_ver = 0, e_to = 0, e_ovr = 0;

    function automatic logic [31:0] crc_ref();
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (pl[i]) begin
            c ^= {24'h0, pl[i]};
            for (int k = 0; k < 8; k++) c = (c >> 1) ^ (32'hEDB8_8320 & {32{c[0]}});
        end
        return ~c;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_head_payload(input logic [7:0] hdr);
        logic [15:0] n;
        n = 16'(pl.size());
        send_byte(8'hAA);
        send_byte(hdr);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        foreach (pl[i]) send_byte(pl[i]);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input bit corrupt);
        logic [31:0] c;
        c = crc_ref();
        if (corrupt) c ^= 32'h0100_0000;
        send_head_payload(hdr);
        send_byte(c[7:0]);
        send_byte(c[15:8]);
        send_byte(c[23:16]);
        send_byte(c[31:24]);
    endtask

    task automatic fill_random(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (frames_out < n && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_done", int'(frames_out >= n), 1);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!out_valid && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("valid_seen", out_valid, 1);
    endtask

    task automatic check_payload(input logic [7:0] hdr);
        exp_frames++;
        exp_good++;
        wait_frames(exp_frames);
        check("out_count", got_q.size(), rd_idx + pl.size());
        foreach (pl[i]) begin
            check("out_data", got_q[rd_idx + i], pl[i]);
            check("out_last", got_last_q[rd_idx + i], (i == pl.size() - 1));
        end
        rd_idx += pl.size();
        check("frame_cmd", got_cmd, hdr[5:0]);
        check("frame_ver", got_ver, hdr[7:6]);
        check("frame_len", got_len, pl.size());
        check("good_cnt", good_cnt, exp_good);
    endtask

    task automatic check_status();
        repeat (2) begin @(posedge clk); #1; end
        check("n_err_crc", n_crc, e_crc);
        check("n_err_len", n_len, e_len);
        check("n_err_ver", n_ver, e_ver);
        check("n_err_timeout", n_to, e_to);
        check("n_rx_overrun", n_ovr, e_ovr);
        check("good_cnt", good_cnt, exp_good);
        check("bad_cnt", bad_cnt, exp_bad);
        check("frames_out", frames_out, exp_frames);
    endtask

    initial begin
        logic [7:0] hdr;
        logic [15:0] bl;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_last", {out_valid, out_last}, 0);
        check("rst_data", out_data, 0);
        check("rst_side", {frame_ver, frame_cmd, frame_len}, 0);
        check("rst_cnts", {good_cnt, bad_cnt}, 0);
        check("rst_pulses", {err_crc, err_len, err_ver, err_timeout, rx_overrun}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Check vector "123456789", CRC CBF43926 sent little-endian
        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
        send_head_payload(8'h01);
        send_byte(8'h26);
        send_byte(8'h39);
        send_byte(8'hF4);
        send_byte(8'hCB);
        @(negedge clk);
        check("lat_check_cycle", out_valid, 0);
        @(negedge clk);
        check("lat_first_valid", out_valid, 1);
        check("lat_first_data", out_data, 8'h31);
        check_payload(8'h01);
        check_status();

        // Same frame with a bad final CRC byte, then a good frame
        send_head_payload(8'h01);
        send_byte(8'h26);
        send_byte(8'h39);
        send_byte(8'hF4);
        send_byte(8'hCA);
        e_crc++;
        exp_bad++;
        check_status();
        check("crc_bad_no_data", got_q.size(), rd_idx);
        fill_random(5);
        send_frame(8'h4A, 1'b0);
        check_payload(8'h4A);

        // Version 3 header, then zero and oversize lengths
        send_byte(8'hAA);
        send_byte(8'hC1);
        e_ver++;
        exp_bad++;
        check_status();
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        e_len++;
        exp_bad++;
        check_status();
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h01); send_byte(8'h01);
        e_len++;
        exp_bad++;
        check_status();
        fill_random(256);
        send_frame(8'h05, 1'b0);
        check_payload(8'h05);
        check_status();

        // Stalled drain with bytes arriving mid-drain
        rdy_mode = 2;
        fill_random(8);
        send_frame(8'h7E, 1'b0);
        wait_valid();
        send_byte(8'hAA);
        send_byte(8'h12);
        e_ovr += 2;
        check_payload(8'h7E);
        rdy_mode = 0;
        check_status();

        // Inter-byte timeout after LEN_H
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h00);
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            check("timeout_edge", err_timeout, (i == 50));
        end
        e_to++;
        exp_bad++;
        check_status();
        send_byte(8'h55);
        fill_random(3);
        send_frame(8'h02, 1'b0);
        check_payload(8'h02);
        check_status();

        // Randomized frames against the model
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int kind;
            kind = $urandom_range(0, 7);
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                logic [7:0] nb;
                nb = 8'($urandom_range(0, 255));
                if (nb == 8'hAA) nb = 8'h55;
                send_byte(nb);
            end
            fill_random($urandom_range(1, 24));
            hdr = {1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63))};
            case (kind)
                0: begin
                    hdr[7] = 1'b1;
                    send_byte(8'hAA);
                    send_byte(hdr);
                    e_ver++;
                    exp_bad++;
                end
                1: begin
                    bl = ($urandom_range(0, 1) == 1) ? 16'h0000 : 16'($urandom_range(257, 65535));
                    send_byte(8'hAA);
                    send_byte(hdr);
                    send_byte(bl[15:8]);
                    send_byte(bl[7:0]);
                    e_len++;
                    exp_bad++;
                end
                2: begin
                    send_frame(hdr, 1'b1);
                    e_crc++;
                    exp_bad++;
                end
                default: begin
                    send_frame(hdr, 1'b0);
                    check_payload(hdr);
                end
            endcase
            check_status();
        end
        rdy_mode = 0;

        // Reset mid-payload
        pl.delete();
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h11); send_byte(8'h22);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_good = 0;
        exp_bad  = 0;
        check("rstp_valid", out_valid, 0);
        check("rstp_cnts", {good_cnt, bad_cnt}, 0);
        check("rstp_pulses", {err_crc, err_len, err_ver, err_timeout, rx_overrun}, 0);
        check_status();

        // Reset mid-drain
        rdy_mode = 3;
        fill_random(4);
        send_frame(8'h33, 1'b0);
        wait_valid();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 0;
        check("rstd_valid_last", {out_valid, out_last}, 0);
        check("rstd_data", out_data, 0);
        check("rstd_side", {frame_ver, frame_cmd, frame_len}, 0);
        check("rstd_cnts", {good_cnt, bad_cnt}, 0);
        check_status();

        fill_random(6);
        send_frame(8'h15, 1'b0);
        check_payload(8'h15);
        check_status();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
